move_ctrl: RTL
==============

MOVE_CTRL -- requirements
Module: move_ctrl

Interface
REQ-001 Parameter SPD_INC, 11'd8, frwrd_spd step per clock while accelerating.
REQ-002 Parameter SPD_DEC, 11'd32, frwrd_spd step per clock while decelerating.
REQ-003 Parameter MAX_SPD, 11'h2A0, cruise-speed ceiling.
REQ-004 Parameter SETTLE, 3'd4, consecutive at_hdng cycles required to end a turn (legal 1..7).
REQ-005 clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_vld  in  1  command request.
REQ-008 cmd_hdng  in  12  signed desired heading of command.
REQ-009 cmd_sqrs  in  4  squares to travel after turn (0 = turn only).
REQ-010 cmd_rdy  out  1  controller can accept a command.
REQ-011 stop  in  1  abort request.
REQ-012 at_hdng  in  1  heading-reached flag from heading controller.
REQ-013 cntrIR  in  1  line-crossing sensor level, one rising edge per square.
REQ-014 moving  out  1  enables heading controller and integrator.
REQ-015 dsrd_hdng  out  12  signed heading driven to heading controller.
REQ-016 frwrd_spd  out  11  unsigned forward speed driven to heading controller.
REQ-017 cmd_done  out  1  one-cycle pulse at command completion.

Function
REQ-018 States IDLE, TURN, DRIVE, DECEL; cmd_rdy SHALL equal (state==IDLE); moving SHALL equal (state!=IDLE).
REQ-019 Accept on cmd_vld&cmd_rdy at edge N: latch cmd_hdng into dsrd_hdng and cmd_sqrs into sqr target, clear sqr count and settle count, enter TURN; moving high from N+1.
REQ-020 cmd_vld while cmd_rdy low SHALL be ignored; no queuing.
REQ-021 dsrd_hdng SHALL hold its last latched value in all states including IDLE.
REQ-022 TURN: frwrd_spd 0; settle counter increments while at_hdng high, clears on any low cycle; on reaching SETTLE go DRIVE if target>0, else IDLE with cmd_done.
REQ-023 DRIVE: frwrd_spd += SPD_INC each clock, computed 12-bit, saturating at MAX_SPD (never exceeds).
REQ-024 cntrIR rising edges (registered previous level) counted only in DRIVE; edges in IDLE/TURN/DECEL ignored.
REQ-025 When count equals target, next state DECEL; decel starts the cycle after the final edge is detected.
REQ-026 DECEL: frwrd_spd -= SPD_DEC each clock, saturating at 0; when frwrd_spd is 0 at a clock edge, go IDLE and pulse cmd_done for exactly one cycle.
REQ-027 stop in TURN: go IDLE with cmd_done next edge; stop in DRIVE: go DECEL; stop in DECEL/IDLE: no effect.
REQ-028 stop and final-edge in same DRIVE cycle: single transition to DECEL, count frozen.
REQ-029 cmd_done cycle has cmd_rdy high; a cmd_vld in that cycle SHALL be accepted.
REQ-030 Sqr count 4-bit, no wrap: stops incrementing at target.
REQ-031 frwrd_spd SHALL be 0 in IDLE and TURN.

Reset
REQ-032 rst high at a clock edge: state IDLE, frwrd_spd 0, dsrd_hdng 0, moving 0, cmd_done 0, cmd_rdy 1 after edge, counters 0, edge-detect register 0.
REQ-033 rst mid-command SHALL abort immediately with no cmd_done pulse; rst dominates cmd_vld and stop.

Structure
REQ-034 Shared package move_pkg SHALL hold the state enum and default values of SPD_INC, SPD_DEC, MAX_SPD, SETTLE.
REQ-035 cntrIR rising-edge detection SHALL be a sub-module rise_det (clk, rst, in, pulse).
REQ-036 Single registered state machine plus speed, settle and square registers; no latches; all outputs registered except cmd_rdy and moving (decoded from state).

Verification
REQ-037 Reset then cmd_hdng=12'h3FF, sqrs=0, at_hdng high from cycle 3 -> moving high, frwrd_spd 0, cmd_done pulse after 4 high cycles, dsrd_hdng stays 12'h3FF.
REQ-038 at_hdng toggling high 3 cycles, low 1, high 4 -> TURN exits only after the 4-cycle run.
REQ-039 sqrs=2, defaults -> frwrd_spd ramps 8,16,..,672 and holds 0x2A0; second cntrIR edge -> decrements by 32 to 0 in 21 cycles, one cmd_done.
REQ-040 cntrIR pulses during TURN plus cmd_vld while busy -> ignored; second command accepted in cmd_done cycle.
REQ-041 stop during DRIVE at speed 0x100 -> DECEL, reaches 0 in 8 cycles, cmd_done; stop during TURN -> IDLE next edge with cmd_done.
REQ-042 rst asserted mid-DRIVE -> next edge all outputs at reset values, no cmd_done.

Source files
------------

// File: rtl/move_pkg.sv
// Shared types, widths, state codes and default tuning for the move controller.
package move_pkg;

    localparam int unsigned SPD_W  = 11;
    localparam int unsigned HDNG_W = 12;
    localparam int unsigned SQR_W  = 4;
    localparam int unsigned SET_W  = 3;
    localparam int unsigned ST_W   = 2;

    localparam logic [SPD_W-1:0] SPD_INC_DEF = 11'd8;
    localparam logic [SPD_W-1:0] SPD_DEC_DEF = 11'd32;
    localparam logic [SPD_W-1:0] MAX_SPD_DEF = 11'h2A0;
    localparam logic [SET_W-1:0] SETTLE_DEF  = 3'd4;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_TURN  = 2'd1;
    localparam state_t ST_DRIVE = 2'd2;
    localparam state_t ST_DECEL = 2'd3;

    // Accelerate with one extra bit of headroom, clamped at the ceiling.
    function automatic logic [SPD_W-1:0] spd_up(input logic [SPD_W-1:0] spd,
                                                input logic [SPD_W-1:0] inc,
                                                input logic [SPD_W-1:0] lim);
        logic [SPD_W:0] sum;
        sum = {1'b0, spd} + {1'b0, inc};
        if (sum > {1'b0, lim}) return lim;
        return sum[SPD_W-1:0];
    endfunction

    // Decelerate, clamped at zero.
    function automatic logic [SPD_W-1:0] spd_dn(input logic [SPD_W-1:0] spd,
                                                input logic [SPD_W-1:0] dec);
        if (spd < dec) return SPD_W'(0);
        return spd - dec;
    endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Command/status bundle between the navigator and the move controller.
interface move_ctrl_if;
    import move_pkg::*;

    logic                cmd_vld;
    logic [HDNG_W-1:0]   cmd_hdng;
    logic [SQR_W-1:0]    cmd_sqrs;
    logic                cmd_rdy;
    logic                stop;
    logic                at_hdng;
    logic                cntrIR;
    logic                moving;
    logic [HDNG_W-1:0]   dsrd_hdng;
    logic [SPD_W-1:0]    frwrd_spd;
    logic                cmd_done;

    modport master (
        output cmd_vld, cmd_hdng, cmd_sqrs, stop, at_hdng, cntrIR,
        input  cmd_rdy, moving, dsrd_hdng, frwrd_spd, cmd_done
    );

    modport slave (
        input  cmd_vld, cmd_hdng, cmd_sqrs, stop, at_hdng, cntrIR,
        output cmd_rdy, moving, dsrd_hdng, frwrd_spd, cmd_done
    );

endinterface

// File: rtl/rise_det.sv
// Rising-edge detector: pulse is high while in is high and was low last clock.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    // Previous-level capture.
    always_comb prev_d = in;

    // Previous-level register.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/move_ctrl.sv
// Move controller: turn to heading, drive N squares with speed ramps, then stop.
module move_ctrl
    import move_pkg::*;
#(
    parameter logic [SPD_W-1:0] SPD_INC = SPD_INC_DEF,
    parameter logic [SPD_W-1:0] SPD_DEC = SPD_DEC_DEF,
    parameter logic [SPD_W-1:0] MAX_SPD = MAX_SPD_DEF,
    parameter logic [SET_W-1:0] SETTLE  = SETTLE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    move_ctrl_if.slave  bus
);

    state_t              state_q,  state_d;
    logic [SPD_W-1:0]    spd_q,    spd_d;
    logic [HDNG_W-1:0]   hdng_q,   hdng_d;
    logic [SQR_W-1:0]    tgt_q,    tgt_d;
    logic [SQR_W-1:0]    cnt_q,    cnt_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                done_q,   done_d;

    logic                sqr_edge;
    logic [SET_W:0]      settle_nxt;
    logic [SQR_W-1:0]    cnt_nxt;

    rise_det u_ir_det (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.cntrIR),
        .pulse (sqr_edge)
    );

    // Next-state, speed profile and counter updates.
    always_comb begin
        state_d    = state_q;
        spd_d      = spd_q;
        hdng_d     = hdng_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        settle_nxt = {1'b0, settle_q} + (SET_W+1)'(1);
        cnt_nxt    = cnt_q + SQR_W'(1);

        case (state_q)
            ST_IDLE: begin
                spd_d = '0;
                if (bus.cmd_vld) begin
                    state_d  = ST_TURN;
                    hdng_d   = bus.cmd_hdng;
                    tgt_d    = bus.cmd_sqrs;
                    cnt_d    = '0;
                    settle_d = '0;
                end
            end
            ST_TURN: begin
                spd_d = '0;
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (!bus.at_hdng) begin
                    settle_d = '0;
                end else if (settle_nxt == {1'b0, SETTLE}) begin
                    settle_d = '0;
                    if (tgt_q != '0) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    settle_d = settle_nxt[SET_W-1:0];
                end
            end
            ST_DRIVE: begin
                // Speed holds on the cycle that commits to braking.
                if (bus.stop) begin
                    state_d = ST_DECEL;
                end else if (sqr_edge && (cnt_q != tgt_q)) begin
                    cnt_d = cnt_nxt;
                    if (cnt_nxt == tgt_q) state_d = ST_DECEL;
                    else                  spd_d   = spd_up(spd_q, SPD_INC, MAX_SPD);
                end else begin
                    spd_d = spd_up(spd_q, SPD_INC, MAX_SPD);
                end
            end
            ST_DECEL: begin
                if (spd_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    spd_d = spd_dn(spd_q, SPD_DEC);
                end
            end
            default: begin
                state_d = ST_IDLE;
                spd_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            spd_q    <= '0;
            hdng_q   <= '0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            spd_q    <= spd_d;
            hdng_q   <= hdng_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    assign bus.cmd_rdy   = (state_q == ST_IDLE);
    assign bus.moving    = (state_q != ST_IDLE);
    assign bus.dsrd_hdng = hdng_q;
    assign bus.frwrd_spd = spd_q;
    assign bus.cmd_done  = done_q;

endmodule
